// File: rtl/accum_pkg.sv
// Shared opcode and FSM state encodings for the accumulator file.
package accum_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_XOR  = 3'b101,
        OP_CLR  = 3'b110,
        OP_SHL  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int CNT_W = 3;

    // A shift by zero completes like any single-cycle op; only a non-zero count enters SHIFT.
    function automatic logic is_shift_start(op_e op, logic [CNT_W-1:0] cnt);
        return (op == OP_SHL) && (cnt != '0);
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Single-cycle datapath: arithmetic/logic result, carry/borrow and zero detect.
module accum_alu
    import accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             zero_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        // The extra top bit of the difference is set exactly when b_i > a_i.
        diff    = {1'b0, a_i} - {1'b0, b_i};
        res_o   = a_i;
        carry_o = 1'b0;
        case (op_i)
            OP_LOAD: res_o = b_i;
            OP_ADD: begin
                carry_o = sum[WIDTH];
                res_o   = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                carry_o = diff[WIDTH];
                res_o   = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            OP_AND:  res_o = a_i & b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_CLR:  res_o = '0;
            default: res_o = a_i;
        endcase
        zero_o = (res_o == '0);
    end

endmodule

// File: rtl/accum_file.sv
// Register file of accumulators with single-cycle ALU ops and a bit-serial left shift.
//   state    | meaning
//   ST_IDLE  | accepting requests; single-cycle ops complete here
//   ST_SHIFT | shifting the latched entry one bit per cycle, requests ignored
module accum_file
    import accum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter bit SAT    = 1'b0,
    localparam int SELW  = $clog2(NREGS)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] data,
    input  logic [SELW-1:0]  rd_sel,
    output logic [WIDTH-1:0] accum,
    output logic             busy,
    output logic             valid,
    output logic             zero,
    output logic             carry
);

    logic [WIDTH-1:0] ent_q [NREGS];
    logic [WIDTH-1:0] ent_d [NREGS];
    state_e           state_q, state_d;
    logic [SELW-1:0]  ssel_q, ssel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    op_e              op_v;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_zero;
    logic [WIDTH-1:0] shf_res;

    assign op_v = op_e'(op);

    accum_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .a_i     (ent_q[sel]),
        .b_i     (data),
        .op_i    (op_v),
        .res_o   (alu_res),
        .carry_o (alu_carry),
        .zero_o  (alu_zero)
    );

    always_comb begin
        ent_d   = ent_q;
        state_d = state_q;
        ssel_d  = ssel_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        zero_d  = zero_q;
        carry_d = carry_q;
        shf_res = {ent_q[ssel_q][WIDTH-2:0], 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    if (is_shift_start(op_v, data[CNT_W-1:0])) begin
                        state_d = ST_SHIFT;
                        ssel_d  = sel;
                        cnt_d   = data[CNT_W-1:0];
                    end else if (op_v != OP_NOP) begin
                        ent_d[sel] = alu_res;
                        valid_d    = 1'b1;
                        zero_d     = alu_zero;
                        carry_d    = alu_carry;
                    end
                end
            end
            ST_SHIFT: begin
                ent_d[ssel_q] = shf_res;
                cnt_d         = cnt_q - CNT_W'(1);
                // Flags only move when the whole shift completes.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    zero_d  = (shf_res == '0);
                    carry_d = ent_q[ssel_q][WIDTH-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) ent_q[i] <= '0;
            state_q <= ST_IDLE;
            ssel_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            state_q <= state_d;
            ssel_q  <= ssel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign accum = ent_q[rd_sel];
    assign busy  = (state_q == ST_SHIFT);
    assign valid = valid_q;
    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: doc/accum_file.md
ACCUM_FILE -- requirements
Module: accum_file

Interface
REQ-001 Parameter WIDTH, default 8, data and accumulator width in bits (4..32).
REQ-002 Parameter NREGS, default 4, number of accumulator entries (power of two, 2..16); SELW = clog2(NREGS).
REQ-003 Parameter SAT, default 0, 1 = ADD/SUB saturate instead of wrapping.
REQ-004 clk1  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  operation request, sampled on clk1 rising edge.
REQ-007 op  input  3  operation code (Function section).
REQ-008 sel  input  SELW  destination/source entry of the operation.
REQ-009 data  input  WIDTH  operand; for SHL, data[2:0] is the shift count.
REQ-010 rd_sel  input  SELW  read-port entry select.
REQ-011 accum  output  WIDTH  combinational read of entry rd_sel.
REQ-012 busy  output  1  high while a multi-cycle SHL is in progress.
REQ-013 valid  output  1  one-cycle pulse, the cycle after an entry is updated.
REQ-014 zero  output  1  last completed result == 0.
REQ-015 carry  output  1  carry/borrow/last-shifted-out bit of last completed op.

Function
REQ-016 Opcodes: 000 NOP, 001 LOAD (e=data), 010 ADD (e=e+data), 011 SUB (e=e-data), 100 AND, 101 XOR, 110 CLR (e=0), 111 SHL (e shifted left data[2:0] times, one bit per cycle).
REQ-017 With ena=1, busy=0 and op in 001..110, entry sel SHALL update on that edge; valid, zero, carry SHALL reflect it from the next cycle.
REQ-018 NOP or ena=0 SHALL change no entry, no flag, and leave valid low.
REQ-019 ADD carry = bit WIDTH of unsigned sum; SUB carry = borrow (data > e); AND/XOR/LOAD/CLR clear carry.
REQ-020 SAT=1: ADD overflow SHALL yield all-ones, SUB underflow SHALL yield 0; carry still reports overflow/borrow.
REQ-021 FSM states IDLE, SHIFT; IDLE->SHIFT on accepted SHL with count>0; SHIFT->IDLE when remaining count reaches 0.
REQ-022 SHL count 0 SHALL complete in one cycle like a single-cycle op (entry unchanged, carry=0, valid pulses).
REQ-023 SHL count N>0 SHALL hold busy high exactly N cycles, shift entry one bit per cycle, carry = last bit shifted out, single valid pulse after final shift.
REQ-024 While busy=1, ena SHALL be ignored (no queueing); requester retries after busy falls.
REQ-025 During SHIFT the shifting entry SHALL be latched at acceptance; sel changes have no effect.
REQ-026 accum SHALL show intermediate shift values when rd_sel addresses the shifting entry.
REQ-027 zero and carry SHALL hold their value until the next completed operation.

Reset
REQ-028 rst_n low SHALL asynchronously clear all entries, zero=1, carry=0, valid=0, busy=0, FSM=IDLE.
REQ-029 Reset mid-SHIFT SHALL abort the shift with no valid pulse after release.
REQ-030 First edge after rst_n release SHALL accept a request normally.

Structure
REQ-031 Opcode constants and FSM state encodings SHALL live in shared package accum_pkg.
REQ-032 Combinational datapath (add/sub/sat/logic, carry, zero) SHALL be a sub-module accum_alu; accum_file holds entries, FSM, shift counter.

Verification
REQ-033 WIDTH=8: LOAD e1=0xF0, ADD 0x20 -> e1=0x10, carry=1, zero=0, valid 1 cycle.
REQ-034 SAT=1: LOAD e0=0x05, SUB 0x09 -> e0=0x00, carry=1, zero=1.
REQ-035 LOAD e2=0x81, SHL count 3 -> busy 3 cycles, e2=0x08, carry=0; ena pulses during busy ignored.
REQ-036 SHL count 0 on e3=0x55 -> busy never high, e3=0x55, valid pulses once.
REQ-037 rst_n low during SHL cycle 2 -> all entries 0, zero=1, busy=0, no valid after release.
REQ-038 NREGS=4: LOAD distinct values to e0..e3, sweep rd_sel -> accum returns each value.
